// File: rtl/decode_issue_stage_if.sv
// Fetch-side and issue-side handshake bundle of the decode/issue stage.
// The master side feeds instructions and accepts issued ones; the slave side is the stage.
interface decode_issue_stage_if #(
    parameter int DataWidth  = 32,
    parameter int StateWidth = 4,
    parameter int Func3Width = 3
) ();
    logic                  inValid;
    logic                  inReady;
    logic [DataWidth-1:0]  inInstr;
    logic [DataWidth-1:0]  inPC;

    logic                  outValid;
    logic                  outReady;
    logic [StateWidth-1:0] state;
    logic [Func3Width-1:0] func3;
    logic [DataWidth-1:0]  imm;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [DataWidth-1:0]  PC;

    modport master (
        output inValid, inInstr, inPC, outReady,
        input  inReady, outValid, state, func3, imm, rs1, rs2, rd, PC
    );

    modport slave (
        input  inValid, inInstr, inPC, outReady,
        output inReady, outValid, state, func3, imm, rs1, rs2, rd, PC
    );
endinterface

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: decodes fetched words into controller state codes and operands,
// buffered by an output register plus one skid entry so upstream ready is registered.
module decode_issue_stage #(
    parameter int DataWidth  = 32,
    parameter int StateWidth = 4,
    parameter int Func3Width = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    decode_issue_stage_if.slave  bus,
    output logic                 illegal,
    output logic [DataWidth-1:0] issuedCount
);

    typedef enum logic [StateWidth-1:0] {
        IDLE            = StateWidth'(0),
        RegWrite        = StateWidth'(1),
        MemReadRegWrite = StateWidth'(2),
        MemWrite        = StateWidth'(3),
        PCSelectWrite   = StateWidth'(4),
        PCWrite         = StateWidth'(5)
    } stateType;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    typedef struct packed {
        stateType              state;
        logic [Func3Width-1:0] func3;
        logic [DataWidth-1:0]  imm;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [DataWidth-1:0]  pc;
    } entryType;

    function automatic logic [31:0] immI(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [31:0] immS(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [31:0] immB(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] immU(input logic [31:0] instr);
        return {instr[31:12], 12'd0};
    endfunction

    function automatic logic [31:0] immJ(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic [DataWidth-1:0] signExtend(input logic [31:0] value);
        return DataWidth'($signed(value));
    endfunction

    logic [6:0]          opcode_s;
    stateType            decState_s;
    logic [31:0]         decImm_s;
    logic                decIllegal_s;
    entryType            newEntry_s;

    logic                outValid_r;
    entryType            outEntry_r;
    logic                skidFull_r;
    entryType            skidEntry_r;
    logic                inReady_r;
    logic                illegal_r;
    logic [DataWidth-1:0] issuedCount_r;

    logic                accept_s;
    logic                advance_s;
    logic                outFree_s;
    logic                outValidNext_s;
    entryType            outEntryNext_s;
    logic                skidFullNext_s;
    entryType            skidEntryNext_s;

    // Opcode decode into state code, immediate and illegal flag.
    always_comb begin
        opcode_s     = bus.inInstr[6:0];
        decState_s   = IDLE;
        decImm_s     = 32'd0;
        decIllegal_s = 1'b0;
        case (opcode_s)
            OpR: begin
                decState_s = RegWrite;
                decImm_s   = 32'd0;
            end
            OpIAlu: begin
                decState_s = RegWrite;
                decImm_s   = immI(bus.inInstr[31:0]);
            end
            OpLui, OpAuipc: begin
                decState_s = RegWrite;
                decImm_s   = immU(bus.inInstr[31:0]);
            end
            OpLoad: begin
                decState_s = MemReadRegWrite;
                decImm_s   = immI(bus.inInstr[31:0]);
            end
            OpStore: begin
                decState_s = MemWrite;
                decImm_s   = immS(bus.inInstr[31:0]);
            end
            OpBranch: begin
                decState_s = PCSelectWrite;
                decImm_s   = immB(bus.inInstr[31:0]);
            end
            OpJal: begin
                decState_s = PCWrite;
                decImm_s   = immJ(bus.inInstr[31:0]);
            end
            OpJalr: begin
                decState_s = PCWrite;
                decImm_s   = immI(bus.inInstr[31:0]);
            end
            default: begin
                decState_s   = IDLE;
                decImm_s     = 32'd0;
                decIllegal_s = 1'b1;
            end
        endcase
    end

    // Pack the decoded fields of the offered instruction into one buffer entry.
    always_comb begin
        newEntry_s       = '0;
        newEntry_s.state = decState_s;
        newEntry_s.func3 = Func3Width'(bus.inInstr[14:12]);
        newEntry_s.imm   = signExtend(decImm_s);
        newEntry_s.rs1   = bus.inInstr[19:15];
        newEntry_s.rs2   = bus.inInstr[24:20];
        newEntry_s.rd    = bus.inInstr[11:7];
        newEntry_s.pc    = bus.inPC;
    end

    // Flush kills the offer too, so a dropped instruction can never set illegal.
    assign accept_s  = bus.inValid && inReady_r && !flush;
    assign advance_s = outValid_r && bus.outReady;
    assign outFree_s = !outValid_r || advance_s;

    // Output/skid steering: the skid entry is older, so it always moves out first.
    always_comb begin
        outValidNext_s  = outValid_r;
        outEntryNext_s  = outEntry_r;
        skidFullNext_s  = skidFull_r;
        skidEntryNext_s = skidEntry_r;
        if (flush) begin
            outValidNext_s       = 1'b0;
            outEntryNext_s.state = IDLE;
            skidFullNext_s       = 1'b0;
        end else if (outFree_s) begin
            if (skidFull_r) begin
                outEntryNext_s = skidEntry_r;
                outValidNext_s = 1'b1;
                skidFullNext_s = 1'b0;
            end else if (accept_s) begin
                outEntryNext_s = newEntry_s;
                outValidNext_s = 1'b1;
            end else begin
                outValidNext_s       = 1'b0;
                outEntryNext_s.state = IDLE;
            end
        end else begin
            if (accept_s) begin
                skidEntryNext_s = newEntry_s;
                skidFullNext_s  = 1'b1;
            end else begin
                skidFullNext_s  = skidFull_r;
            end
        end
    end

    // Buffer, ready, sticky illegal and handshake counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outValid_r    <= 1'b0;
            outEntry_r    <= '0;
            skidFull_r    <= 1'b0;
            skidEntry_r   <= '0;
            inReady_r     <= 1'b1;
            illegal_r     <= 1'b0;
            issuedCount_r <= '0;
        end else begin
            outValid_r    <= outValidNext_s;
            outEntry_r    <= outEntryNext_s;
            skidFull_r    <= skidFullNext_s;
            skidEntry_r   <= skidEntryNext_s;
            inReady_r     <= !skidFullNext_s;
            illegal_r     <= illegal_r || (accept_s && decIllegal_s);
            issuedCount_r <= advance_s ? issuedCount_r + DataWidth'(1) : issuedCount_r;
        end
    end

    assign bus.inReady  = inReady_r;
    assign bus.outValid = outValid_r;
    assign bus.state    = outEntry_r.state;
    assign bus.func3    = outEntry_r.func3;
    assign bus.imm      = outEntry_r.imm;
    assign bus.rs1      = outEntry_r.rs1;
    assign bus.rs2      = outEntry_r.rs2;
    assign bus.rd       = outEntry_r.rd;
    assign bus.PC       = outEntry_r.pc;
    assign illegal      = illegal_r;
    assign issuedCount  = issuedCount_r;

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Upstream neighbour of the execute/write-back controller.
- Accepts fetched instruction words with their PC over a valid/ready handshake and decodes them.
- Produces the registered `state` code, `func3`, immediate, register addresses and PC that the controller consumes.
- Contains a 2-entry skid buffer so upstream back-pressure is fully registered. Supports flush on taken branch/jump.

Parameters:
- DataWidth, 32, instruction/PC/immediate width
- StateWidth, 4, width of issued state code
- Func3Width, 3, width of func3 field

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- inValid  in  1  fetched instruction valid
- inReady  out  1  stage can accept an instruction
- inInstr  in  32  instruction word
- inPC  in  32  PC of inInstr
- flush  in  1  kill all held instructions (driven from pcWriteEnable outside reset)
- outReady  in  1  downstream accepts current output
- outValid  out  1  output register holds a live instruction
- state  out  4  issued state code
- func3  out  3  instr[14:12]
- imm  out  32  sign-extended immediate
- rs1, rs2, rd  out  5 each  register addresses
- PC  out  32  PC of issued instruction
- illegal  out  1  sticky, unknown opcode seen
- issuedCount  out  32  count of output handshakes

Behaviour:
- State encoding: IDLE=0, RegWrite=1, MemReadRegWrite=2, MemWrite=3, PCSelectWrite=4, PCWrite=5.
- Opcode → state mapping:
  - 0110011 (R), 0010011 (I-ALU), 0110111 (LUI), 0010111 (AUIPC) → RegWrite
  - 0000011 → MemReadRegWrite
  - 0100011 → MemWrite
  - 1100011 → PCSelectWrite
  - 1101111, 1100111 → PCWrite
  - anything else → IDLE, and set illegal on its acceptance
- Immediate formats, all sign-extended from instr[31]:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R-type: imm = 0
- Decode is combinational on inInstr. Results are captured into registers; no output is driven combinationally from inputs.
- Latency: an instruction accepted in cycle N appears at outValid in cycle N+1 when the stage is empty.
- Buffering: one output register plus one skid register.
  - inReady = !skidFull, registered.
  - Accept on inValid && inReady.
  - Output advances on outValid && outReady.
  - Output empty or advancing: the skid entry, if present, moves to output first; otherwise the new instruction does.
  - Output stalled and skid empty: an accepted instruction goes to skid.
  - Order is strictly preserved.
- Simultaneous accept and advance with skid full cannot occur, because inReady=0 in that case.
- Flush (synchronous, highest priority after reset):
  - Next edge: outValid=0, skid cleared, state=IDLE, inReady=1.
  - An instruction offered in the flush cycle is dropped, not accepted.
  - issuedCount still counts a handshake that completes in the flush cycle.
- While outValid=0, state is forced to IDLE. Other outputs hold their last values.
- issuedCount increments by 1 per output handshake and wraps at 2^32.
- illegal is sticky and cleared only by reset.
- Reset (asynchronous assert, synchronous-safe deassert): all of the following immediately, including mid-transfer.
  - outValid=0, state=IDLE, func3=0, imm=0, rs1=rs2=rd=0, PC=0
  - skid empty, inReady=1, illegal=0, issuedCount=0

Test Plan:
- Reset mid-stream: reset=0 while outValid=1 → same-cycle outValid=0, state=0, inReady=1, issuedCount=0; deassert → first instruction issues one cycle after acceptance.
- Decode sweep, outReady=1:
  - 0x00A00093 (addi x1,x0,10) → state=1, imm=10, rd=1, rs1=0
  - 0xFE112E23 (sw x1,-4(x2)) → state=3, imm=0xFFFFFFFC, func3=2
  - 0x00208463 (beq x1,x2,8) → state=4, imm=8
  - 0x008000EF (jal x1,8) → state=5, imm=8
  - 0x12345037 (lui x0,0x12345) → state=1, imm=0x12345000
- Back-pressure: outReady=0 with three back-to-back offers → first in output, second in skid, inReady=0 on the third; release → issue order preserved, issuedCount=3 after drain.
- Flush: skid and output both full, flush=1 with inValid=1 → next cycle outValid=0, state=0, inReady=1; the offered instruction never issues.
- Illegal: 0x0000007F accepted → issues state=0 with outValid=1, illegal=1 remains set after later legal instructions, until reset.
- Counter wrap: preload via 2^32 handshakes (or force) → issuedCount returns from 0xFFFFFFFF to 0.
